// File: rtl/keyboard_matrix_pkg.sv
// Shared constants and types for the PET keyboard matrix: PIA register map,
// Port A key-column bit positions, matrix geometry and row/column types.
package keyboard_matrix_pkg;

  localparam int KBD_COL_COUNT  = 10;
  localparam int KBD_ADDR_WIDTH = 4;
  localparam int KBD_ROW_COUNT  = 8;

  localparam logic [7:0] KBD_IDLE_ROW = 8'hFF;

  localparam logic [1:0] PIA_PORTA = 2'd0;
  localparam logic [1:0] PIA_CRA   = 2'd1;
  localparam logic [1:0] PIA_PORTB = 2'd2;
  localparam logic [1:0] PIA_CRB   = 2'd3;

  // Control register bit 2 steers Port A/B accesses between DDR and data reg.
  localparam int PIA_CR_DDR_SEL  = 2;
  localparam int PIA_PORTA_KEY_A = 0;
  localparam int PIA_PORTA_KEY_D = 3;

  typedef logic [KBD_ADDR_WIDTH-1:0] kbd_col_t;
  typedef logic [KBD_ROW_COUNT-1:0]  kbd_row_t;

  function automatic logic col_in_range(input kbd_col_t col, input int count);
    return int'(col) < count;
  endfunction

endpackage

// File: rtl/pia1_port_snoop.sv
// Shadows the PIA1 CRA/CRB/ORA (and DDRA when KBD_DDRA_TRACK_EN is defined)
// from snooped CPU writes; presents the keyboard column selected by the ROM scan.
module pia1_port_snoop
  import keyboard_matrix_pkg::*;
(
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      pia1_cs_i,
  input  logic [1:0]                cpu_rs_i,
  input  logic                      cpu_we_i,
  input  logic                      cpu_strobe_i,
  input  logic [7:0]                cpu_data_i,
  output logic [KBD_ADDR_WIDTH-1:0] col_o,
  output logic                      crb2_o
);

  logic       snoop_wr;
  logic       cra2_q;
  logic       crb2_q;
  logic [3:0] ora_q;
  logic [3:0] key_nibble;
  logic       unused_data;

  assign snoop_wr    = cpu_strobe_i & pia1_cs_i & cpu_we_i;
  assign key_nibble  = cpu_data_i[PIA_PORTA_KEY_D:PIA_PORTA_KEY_A];
  assign unused_data = ^cpu_data_i[7:4];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cra2_q <= 1'b0;
      crb2_q <= 1'b0;
      ora_q  <= 4'h0;
    end else if (snoop_wr) begin
      case (cpu_rs_i)
        PIA_CRA:   cra2_q <= cpu_data_i[PIA_CR_DDR_SEL];
        PIA_CRB:   crb2_q <= cpu_data_i[PIA_CR_DDR_SEL];
        PIA_PORTA: if (cra2_q) ora_q <= key_nibble;
        default: ;
      endcase
    end
  end

`ifdef KBD_DDRA_TRACK_EN
  logic [3:0] ddra_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ddra_q <= 4'h0;
    end else if (snoop_wr && cpu_rs_i == PIA_PORTA && !cra2_q) begin
      ddra_q <= key_nibble;
    end
  end

  // Pins configured as inputs float high, as on the real PIA.
  assign col_o = ora_q | ~ddra_q;
`else
  assign col_o = ora_q;
`endif

  assign crb2_o = crb2_q;

endmodule

// File: rtl/keyboard_matrix.sv
// PET keyboard matrix: MCU writes rows over Wishbone, the 6502 reads the row
// byte for the snooped PIA1 column. Optional DDRA tracking via KBD_DDRA_TRACK_EN.
module keyboard_matrix
  import keyboard_matrix_pkg::*;
#(
  parameter int COL_COUNT  = KBD_COL_COUNT,
  parameter int ADDR_WIDTH = KBD_ADDR_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [7:0]            wb_dat_i,
  output logic [7:0]            wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  input  logic                  pia1_cs_i,
  input  logic [1:0]            cpu_rs_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_strobe_i,
  input  logic [7:0]            cpu_data_i,
  output logic [7:0]            cpu_data_o,
  output logic                  cpu_data_oe_o
);

  kbd_row_t                  matrix [COL_COUNT];
  kbd_row_t                  wb_dat_q;
  kbd_row_t                  row_q;
  logic                      ack_q;
  logic                      wb_acc;
  logic                      wb_hit;
  logic [KBD_ADDR_WIDTH-1:0] col;
  logic                      crb2;

  pia1_port_snoop u_snoop (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .pia1_cs_i    (pia1_cs_i),
    .cpu_rs_i     (cpu_rs_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_strobe_i (cpu_strobe_i),
    .cpu_data_i   (cpu_data_i),
    .col_o        (col),
    .crb2_o       (crb2)
  );

  assign wb_acc = wb_cyc_i & wb_stb_i;
  assign wb_hit = int'(wb_adr_i) < COL_COUNT;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < COL_COUNT; i++) matrix[i] <= KBD_IDLE_ROW;
    end else if (wb_acc && wb_we_i && wb_hit) begin
      matrix[wb_adr_i] <= wb_dat_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ack_q    <= 1'b0;
      wb_dat_q <= KBD_IDLE_ROW;
    end else begin
      ack_q <= wb_acc;
      if (wb_acc && !wb_we_i) wb_dat_q <= wb_hit ? matrix[wb_adr_i] : KBD_IDLE_ROW;
    end
  end

  // Columns 10-15 decode to nothing on the 74145, so the row reads idle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_q <= KBD_IDLE_ROW;
    end else begin
      row_q <= col_in_range(col, COL_COUNT) ? matrix[col] : KBD_IDLE_ROW;
    end
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = wb_dat_q;
  assign wb_stall_o    = 1'b0;
  assign cpu_data_o    = row_q;
  assign cpu_data_oe_o = pia1_cs_i & ~cpu_we_i & (cpu_rs_i == PIA_PORTB) & crb2;

endmodule
